// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its environment: clock
// inputs from digital_clock, user controls, and the alarm status outputs.
interface alarm_controller_if;
  // Current time from digital_clock
  logic [5:0] hrs;
  logic [5:0] mins;
  logic [5:0] secs;
  // User controls
  logic       alarm_en;
  logic       set_en;
  logic [5:0] set_hrs;
  logic [5:0] set_mins;
  logic       snooze;
  logic       stop;
  // Alarm status
  logic [5:0] alarm_hrs;
  logic [5:0] alarm_mins;
  logic       ringing;
  logic       buzzer;
  logic [2:0] snooze_cnt;
  logic       set_err;

  // Environment side: drives time and controls, observes status
  modport master (
    output hrs, mins, secs, alarm_en, set_en, set_hrs, set_mins, snooze, stop,
    input  alarm_hrs, alarm_mins, ringing, buzzer, snooze_cnt, set_err
  );

  // Controller side
  modport slave (
    input  hrs, mins, secs, alarm_en, set_en, set_hrs, set_mins, snooze, stop,
    output alarm_hrs, alarm_mins, ringing, buzzer, snooze_cnt, set_err
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: watches the time from digital_clock, rings at the stored
// alarm time, supports a bounded number of snoozes and stops ringing on its
// own after a timeout. All second counting comes from changes on secs.
module alarm_controller #(
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active low
  alarm_controller_if.slave bus
);

  localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SECS);
  localparam logic [9:0] RING_LIM   = 10'(RING_SECS);
  localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] secs_q, secs_d;
  logic [5:0] alarm_hrs_q, alarm_hrs_d;
  logic [5:0] alarm_mins_q, alarm_mins_d;
  logic       ringing_q, ringing_d;
  logic       buzzer_q, buzzer_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       set_err_q, set_err_d;
  logic [9:0] timer_q, timer_d;

  logic       tick;
  logic       match;
  logic       set_ok;
  logic       active;
  logic [9:0] timer_inc;

  // A new second is any change on secs, so midnight wrap is just another tick
  assign tick      = (bus.secs != secs_q);
  assign match     = tick && (bus.secs == 6'd0) &&
                     (bus.hrs == alarm_hrs_q) && (bus.mins == alarm_mins_q);
  assign set_ok    = (bus.set_hrs < 6'd24) && (bus.set_mins < 6'd60);
  assign active    = (state_q == RINGING) || (state_q == SNOOZED);
  // Timer saturates instead of wrapping
  assign timer_inc = (timer_q == 10'h3FF) ? timer_q : timer_q + 10'd1;

  // Next-state and output logic; priority: disable > set > stop > snooze > timer/match
  always_comb begin
    state_d      = state_q;
    secs_d       = bus.secs;
    alarm_hrs_d  = alarm_hrs_q;
    alarm_mins_d = alarm_mins_q;
    buzzer_d     = buzzer_q;
    snooze_cnt_d = snooze_cnt_q;
    timer_d      = timer_q;
    set_err_d    = 1'b0;

    if (!bus.alarm_en) begin
      state_d      = IDLE;
      buzzer_d     = 1'b0;
      snooze_cnt_d = 3'd0;
      timer_d      = 10'd0;
    end else if (bus.set_en) begin
      if (set_ok) begin
        alarm_hrs_d  = bus.set_hrs;
        alarm_mins_d = bus.set_mins;
        if (active) begin
          snooze_cnt_d = 3'd0;
        end
        state_d  = ARMED;
        timer_d  = 10'd0;
        buzzer_d = 1'b0;
      end else begin
        // Rejected: everything holds, only the error pulse is raised
        set_err_d = 1'b1;
      end
    end else if (bus.stop && active) begin
      state_d      = ARMED;
      snooze_cnt_d = 3'd0;
      timer_d      = 10'd0;
      buzzer_d     = 1'b0;
    end else if (bus.snooze && (state_q == RINGING) && (snooze_cnt_q < SNOOZE_MAX)) begin
      state_d      = SNOOZED;
      snooze_cnt_d = snooze_cnt_q + 3'd1;
      timer_d      = 10'd0;
      buzzer_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (match) begin
            state_d  = RINGING;
            timer_d  = 10'd0;
            buzzer_d = 1'b1;
          end
        end
        RINGING: begin
          // A match while ringing is deliberately not looked at here
          if (tick) begin
            if (timer_inc >= RING_LIM) begin
              state_d      = ARMED;
              snooze_cnt_d = 3'd0;
              timer_d      = 10'd0;
              buzzer_d     = 1'b0;
            end else begin
              timer_d  = timer_inc;
              buzzer_d = ~buzzer_q;
            end
          end
        end
        SNOOZED: begin
          if (tick) begin
            if (timer_inc >= SNOOZE_LIM) begin
              state_d  = RINGING;
              timer_d  = 10'd0;
              buzzer_d = 1'b1;
            end else begin
              timer_d = timer_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ringing_d = (state_d == RINGING);
  end

  // State and registered outputs; reset clears everything including the alarm time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      secs_q       <= 6'd0;
      alarm_hrs_q  <= 6'd0;
      alarm_mins_q <= 6'd0;
      ringing_q    <= 1'b0;
      buzzer_q     <= 1'b0;
      snooze_cnt_q <= 3'd0;
      set_err_q    <= 1'b0;
      timer_q      <= 10'd0;
    end else begin
      state_q      <= state_d;
      secs_q       <= secs_d;
      alarm_hrs_q  <= alarm_hrs_d;
      alarm_mins_q <= alarm_mins_d;
      ringing_q    <= ringing_d;
      buzzer_q     <= buzzer_d;
      snooze_cnt_q <= snooze_cnt_d;
      set_err_q    <= set_err_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.alarm_hrs  = alarm_hrs_q;
  assign bus.alarm_mins = alarm_mins_q;
  assign bus.ringing    = ringing_q;
  assign bus.buzzer     = buzzer_q;
  assign bus.snooze_cnt = snooze_cnt_q;
  assign bus.set_err    = set_err_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios followed by randomized
// controls, every cycle compared against a behavioural reference model.
module tb_alarm_controller;

  localparam int SNZ  = 5;
  localparam int RNG  = 4;
  localparam int MAXS = 2;

  // Reference model modes
  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_RING = 2;
  localparam int M_NAP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alarm_controller_if bus_if ();

  alarm_controller #(
    .SNOOZE_SECS(SNZ),
    .RING_SECS  (RNG),
    .MAX_SNOOZE (MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  int m_mode, m_ah, m_am, m_timer, m_cnt, m_prev;
  bit m_ring, m_buzz, m_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_ah = 0; m_am = 0; m_timer = 0; m_cnt = 0; m_prev = 0;
    m_ring = 0; m_buzz = 0; m_err = 0;
  endtask

  // One clock edge of the alarm rules, evaluated on the inputs sampled at that edge
  task automatic model_step();
    bit tk;
    bit ok;
    tk     = (int'(bus_if.secs) != m_prev);
    m_prev = int'(bus_if.secs);
    m_err  = 0;
    ok     = (bus_if.set_hrs < 24) && (bus_if.set_mins < 60);
    if (!bus_if.alarm_en) begin
      m_mode = M_OFF; m_buzz = 0; m_cnt = 0; m_timer = 0;
    end else if (bus_if.set_en) begin
      if (ok) begin
        m_ah = int'(bus_if.set_hrs); m_am = int'(bus_if.set_mins);
        if (m_mode == M_RING || m_mode == M_NAP) m_cnt = 0;
        m_mode = M_WAIT; m_timer = 0; m_buzz = 0;
      end else begin
        m_err = 1;
      end
    end else if (bus_if.stop && (m_mode == M_RING || m_mode == M_NAP)) begin
      m_mode = M_WAIT; m_cnt = 0; m_timer = 0; m_buzz = 0;
    end else if (bus_if.snooze && m_mode == M_RING && m_cnt < MAXS) begin
      m_mode = M_NAP; m_cnt = m_cnt + 1; m_timer = 0; m_buzz = 0;
    end else if (m_mode == M_OFF) begin
      m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (tk && bus_if.secs == 0 && int'(bus_if.hrs) == m_ah && int'(bus_if.mins) == m_am) begin
        m_mode = M_RING; m_timer = 0; m_buzz = 1;
      end
    end else if (tk) begin
      m_timer = (m_timer < 1023) ? m_timer + 1 : 1023;
      if (m_mode == M_RING) begin
        if (m_timer >= RNG) begin
          m_mode = M_WAIT; m_cnt = 0; m_timer = 0; m_buzz = 0;
        end else begin
          m_buzz = !m_buzz;
        end
      end else if (m_timer >= SNZ) begin
        m_mode = M_RING; m_timer = 0; m_buzz = 1;
      end
    end
    m_ring = (m_mode == M_RING);
  endtask

  task automatic compare_all();
    chk("ringing",    16'(bus_if.ringing),    16'(m_ring));
    chk("buzzer",     16'(bus_if.buzzer),     16'(m_buzz));
    chk("snooze_cnt", 16'(bus_if.snooze_cnt), 16'(m_cnt));
    chk("set_err",    16'(bus_if.set_err),    16'(m_err));
    chk("alarm_hrs",  16'(bus_if.alarm_hrs),  16'(m_ah));
    chk("alarm_mins", 16'(bus_if.alarm_mins), 16'(m_am));
  endtask

  // Advance one clock, update the model, check all outputs 1 ns after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic hold(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus_if.hrs = 6'(h); bus_if.mins = 6'(m); bus_if.secs = 6'(s);
  endtask

  task automatic step_sec(input int h, input int m, input int s);
    set_time(h, m, s);
    hold(10);
  endtask

  task automatic do_set(input int h, input int m);
    bus_if.set_en = 1'b1; bus_if.set_hrs = 6'(h); bus_if.set_mins = 6'(m);
    cycle();
    bus_if.set_en = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus_if.snooze = 1'b1; cycle(); bus_if.snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_if.stop = 1'b1; cycle(); bus_if.stop = 1'b0;
  endtask

  initial begin
    int h, m, s, r;
    bus_if.alarm_en = 1'b0; bus_if.set_en = 1'b0; bus_if.snooze = 1'b0; bus_if.stop = 1'b0;
    bus_if.set_hrs = 6'd0; bus_if.set_mins = 6'd0;
    set_time(0, 0, 0);
    model_reset();

    // Reset state
    #12;
    chk("rst_ringing",    16'(bus_if.ringing),    16'd0);
    chk("rst_buzzer",     16'(bus_if.buzzer),     16'd0);
    chk("rst_snooze_cnt", 16'(bus_if.snooze_cnt), 16'd0);
    chk("rst_set_err",    16'(bus_if.set_err),    16'd0);
    chk("rst_alarm_hrs",  16'(bus_if.alarm_hrs),  16'd0);
    chk("rst_alarm_mins", 16'(bus_if.alarm_mins), 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Set + match
    bus_if.alarm_en = 1'b1;
    set_time(7, 29, 55);
    cycle();
    do_set(7, 30);
    chk("set_load_hrs",  16'(bus_if.alarm_hrs),  16'd7);
    chk("set_load_mins", 16'(bus_if.alarm_mins), 16'd30);
    step_sec(7, 29, 58);
    step_sec(7, 29, 59);
    set_time(7, 30, 0);
    cycle();
    chk("ring_on_match", 16'(bus_if.ringing), 16'd1);
    chk("buzz_entry",    16'(bus_if.buzzer),  16'd1);
    hold(9);
    for (int i = 1; i <= 3; i++) begin
      set_time(7, 30, i);
      cycle();
      chk("buzz_toggle", 16'(bus_if.buzzer),  16'((i % 2 == 0) ? 1 : 0));
      chk("ring_held",   16'(bus_if.ringing), 16'd1);
      hold(9);
    end

    // Auto-stop on the 4th tick, no re-fire for the rest of the minute
    set_time(7, 30, 4);
    cycle();
    chk("auto_stop", 16'(bus_if.ringing), 16'd0);
    hold(9);
    for (int i = 5; i <= 59; i++) step_sec(7, 30, i);
    chk("no_refire", 16'(bus_if.ringing), 16'd0);

    // Snooze limit
    step_sec(7, 29, 59);
    set_time(7, 30, 0);
    hold(3);
    chk("ring_again", 16'(bus_if.ringing), 16'd1);
    pulse_snooze();
    chk("snooze1_ring", 16'(bus_if.ringing),    16'd0);
    chk("snooze1_cnt",  16'(bus_if.snooze_cnt), 16'd1);
    hold(6);
    for (int i = 1; i <= 4; i++) step_sec(7, 30, i);
    chk("snooze1_quiet", 16'(bus_if.ringing), 16'd0);
    set_time(7, 30, 5);
    cycle();
    chk("snooze1_resume", 16'(bus_if.ringing), 16'd1);
    hold(2);
    pulse_snooze();
    chk("snooze2_cnt", 16'(bus_if.snooze_cnt), 16'd2);
    hold(6);
    for (int i = 6; i <= 9; i++) step_sec(7, 30, i);
    set_time(7, 30, 10);
    cycle();
    chk("snooze2_resume", 16'(bus_if.ringing), 16'd1);
    hold(2);
    pulse_snooze();
    chk("snooze3_ignored", 16'(bus_if.ringing),    16'd1);
    chk("snooze3_cnt",     16'(bus_if.snooze_cnt), 16'd2);
    pulse_stop();
    chk("stop_ring", 16'(bus_if.ringing),    16'd0);
    chk("stop_cnt",  16'(bus_if.snooze_cnt), 16'd0);
    hold(5);

    // Invalid sets
    do_set(24, 10);
    chk("bad_hrs_err", 16'(bus_if.set_err), 16'd1);
    cycle();
    chk("bad_hrs_err_end", 16'(bus_if.set_err), 16'd0);
    do_set(5, 60);
    chk("bad_mins_err", 16'(bus_if.set_err), 16'd1);
    cycle();
    chk("bad_mins_err_end", 16'(bus_if.set_err), 16'd0);
    chk("bad_keep_hrs",  16'(bus_if.alarm_hrs),  16'd7);
    chk("bad_keep_mins", 16'(bus_if.alarm_mins), 16'd30);

    // stop and snooze together while ringing
    step_sec(7, 29, 59);
    set_time(7, 30, 0);
    hold(3);
    bus_if.stop = 1'b1; bus_if.snooze = 1'b1;
    cycle();
    bus_if.stop = 1'b0; bus_if.snooze = 1'b0;
    chk("both_ring", 16'(bus_if.ringing),    16'd0);
    chk("both_cnt",  16'(bus_if.snooze_cnt), 16'd0);
    hold(6);

    // Disable while snoozed
    step_sec(7, 29, 59);
    set_time(7, 30, 0);
    hold(3);
    pulse_snooze();
    cycle();
    bus_if.alarm_en = 1'b0;
    cycle();
    chk("disable_cnt", 16'(bus_if.snooze_cnt), 16'd0);
    hold(3);
    for (int i = 1; i <= 7; i++) step_sec(7, 30, i);
    chk("disable_no_ring", 16'(bus_if.ringing), 16'd0);
    bus_if.alarm_en = 1'b1;
    hold(2);

    // Midnight wrap
    do_set(0, 0);
    step_sec(23, 59, 59);
    set_time(0, 0, 0);
    cycle();
    chk("midnight_ring", 16'(bus_if.ringing), 16'd1);
    hold(9);

    // Asynchronous reset mid-ring
    do_set(7, 30);
    step_sec(7, 29, 59);
    set_time(7, 30, 0);
    hold(3);
    chk("pre_reset_ring", 16'(bus_if.ringing), 16'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #2;
    chk("async_ringing",    16'(bus_if.ringing),    16'd0);
    chk("async_buzzer",     16'(bus_if.buzzer),     16'd0);
    chk("async_alarm_hrs",  16'(bus_if.alarm_hrs),  16'd0);
    chk("async_alarm_mins", 16'(bus_if.alarm_mins), 16'd0);
    #1;
    rst = 1'b1;
    model_reset();
    hold(3);

    // Randomized controls against the model with a running clock
    h = 6; m = 59; s = 50;
    set_time(h, m, s);
    do_set(7, 0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 10 == 0) begin
        s++;
        if (s == 60) begin s = 0; m++; end
        if (m == 60) begin m = 0; h++; end
        if (h == 24) h = 0;
        set_time(h, m, s);
      end
      bus_if.alarm_en = ($urandom_range(0, 99) != 0);
      bus_if.set_en   = ($urandom_range(0, 59) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        bus_if.set_hrs  = 6'($urandom_range(0, 31));
        bus_if.set_mins = 6'($urandom_range(0, 63));
      end else begin
        bus_if.set_hrs  = 6'(h);
        bus_if.set_mins = 6'((m + int'($urandom_range(0, 2))) % 60);
      end
      bus_if.snooze = ($urandom_range(0, 14) == 0);
      bus_if.stop   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    bus_if.set_en = 1'b0; bus_if.snooze = 1'b0; bus_if.stop = 1'b0;
    hold(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of digital_clock: watches its hrs/mins/secs outputs, holds a programmable alarm time, and drives a ringing/buzzer output.
- Includes snooze with a bounded repeat count and an automatic ring timeout.
- All timing derives from changes on the secs input; the block has no internal prescaler and runs on the same clk as digital_clock.

Parameters:
- SNOOZE_SECS, 300, seconds spent in SNOOZED before ringing resumes (range 1..1023).
- RING_SECS, 60, seconds of unanswered ringing before auto-stop (range 1..1023).
- MAX_SNOOZE, 3, maximum snoozes per alarm event (range 1..7).

Ports:
- clk  input  1  system clock, shared with digital_clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- hrs  input  6  current hours, 0..23, from digital_clock.
- mins  input  6  current minutes, 0..59.
- secs  input  6  current seconds, 0..59.
- alarm_en  input  1  level; 1 = alarm armed.
- set_en  input  1  1-cycle strobe; load set_hrs/set_mins.
- set_hrs  input  6  new alarm hours.
- set_mins  input  6  new alarm minutes.
- snooze  input  1  1-cycle strobe.
- stop  input  1  1-cycle strobe.
- alarm_hrs  output  6  stored alarm hours (registered).
- alarm_mins  output  6  stored alarm minutes (registered).
- ringing  output  1  1 while in RINGING.
- buzzer  output  1  1 Hz pattern while ringing, else 0.
- snooze_cnt  output  3  snoozes used in the current event.
- set_err  output  1  1-cycle pulse on a rejected set_en.

Behaviour:
- Reset (rst=0, async): state=IDLE; alarm_hrs=0, alarm_mins=0, ringing=0, buzzer=0, snooze_cnt=0, set_err=0, secs_q=0, timer=0. All outputs are registered.
- Tick: secs_q captures secs every cycle. tick = (secs != secs_q). All second counting uses tick only.
- Match: tick && secs==0 && hrs==alarm_hrs && mins==alarm_mins. Fires at most once per minute.
- States: IDLE, ARMED, RINGING, SNOOZED. Per-cycle priority, highest first: alarm_en=0 > set_en > stop > snooze > timer/match.
- alarm_en=0: any state goes to IDLE next edge; ringing=0, buzzer=0, snooze_cnt=0, timer=0.
- IDLE: alarm_en=1 moves to ARMED next edge.
- set_en:
  - Accepted when set_hrs<24 and set_mins<60. alarm_hrs/alarm_mins load at the next edge.
  - If state is RINGING or SNOOZED, it goes to ARMED and snooze_cnt clears.
  - Otherwise rejected: set_err=1 for exactly one cycle; registers and state are unchanged.
- ARMED: on match, go to RINGING with timer=0 and buzzer=1. ringing asserts at the edge that samples the new secs=0, i.e. one clk after digital_clock updates secs.
- RINGING:
  - ringing=1. buzzer toggles on each tick.
  - timer increments on each tick.
  - stop: go to ARMED, snooze_cnt=0.
  - snooze with snooze_cnt<MAX_SNOOZE: go to SNOOZED, snooze_cnt+1, timer=0, buzzer=0.
  - snooze with snooze_cnt==MAX_SNOOZE: ignored.
  - Auto-stop: on the tick where timer reaches RING_SECS, go to ARMED and clear snooze_cnt.
  - A match while already RINGING is ignored.
- SNOOZED:
  - ringing=0, buzzer=0. timer increments on each tick.
  - When timer reaches SNOOZE_SECS, go to RINGING with timer=0, buzzer=1.
  - stop: go to ARMED, snooze_cnt=0.
  - snooze: ignored.
- Simultaneous strobes: stop and snooze together means stop wins. set_en with stop means set_en wins, which ends in ARMED anyway.
- The same-cycle tick is still sampled into secs_q even when a higher-priority event takes the transition.
- Midnight wrap (23:59:59 to 00:00:00) is an ordinary tick. An alarm at 00:00 fires on it.
- Timer width is 10 bits and saturates; it never wraps.
- Reset asserted mid-RINGING or mid-SNOOZED: immediate IDLE with outputs at reset values. The stored alarm time is lost.

Test Plan:
- Bench uses SNOOZE_SECS=5, RING_SECS=4, MAX_SNOOZE=2 and drives hrs/mins/secs directly, one secs step per 10 clk.
- Set + match: rst low then high, alarm_en=1, set_en with 7/30. Step 07:29:58 to 07:30:00.
  -> ringing=1 one clk after secs=0; alarm_hrs=7, alarm_mins=30; buzzer toggles 1,0,1,0 on each following tick.
- Auto-stop: no stop after the match.
  -> ringing falls on the 4th tick after entry (secs=4); state ARMED. No re-fire while secs 5..59 pass at 07:30.
- Snooze limit:
  - Snooze during ringing -> ringing=0, snooze_cnt=1; ringing returns 5 ticks later.
  - Snooze again -> snooze_cnt=2. Third snooze -> ignored, ringing stays 1.
  - stop -> snooze_cnt=0, ringing=0.
- Invalid set: set_en with set_hrs=24, set_mins=10, then 5/60.
  -> set_err one-cycle pulse each time; alarm_hrs/mins unchanged at 7/30.
- Priority/disable:
  - stop and snooze in the same cycle while ringing -> ARMED, snooze_cnt=0.
  - alarm_en=0 during SNOOZED -> IDLE; no ring at snooze expiry.
- Midnight + async reset:
  - Alarm 0/0, step 23:59:59 to 00:00:00 -> ringing=1.
  - Pulse rst=0 for 3 ns between clk edges -> ringing, buzzer, alarm_hrs and alarm_mins go to 0 immediately, without waiting for a clk edge.
